// File: rtl/svm_batch_pkg.sv
// Shared types for the batch receiver: default widths, FSM encoding and
// the stored transaction record.
package svm_batch_pkg;

  localparam int unsigned DEFAULT_ID_WIDTH  = 64;
  localparam int unsigned DEFAULT_DEP_WIDTH = 1024;

  typedef enum logic [1:0] {
    RECV  = 2'd0,
    SUMM  = 2'd1,
    DRAIN = 2'd2
  } rx_state_t;

  // One buffered transaction plus the conflict flag computed on arrival.
  typedef struct packed {
    logic [DEFAULT_ID_WIDTH-1:0]  owner_id;
    logic [DEFAULT_DEP_WIDTH-1:0] read_deps;
    logic [DEFAULT_DEP_WIDTH-1:0] write_deps;
    logic                         conflict;
  } txn_t;

endpackage

// File: rtl/batch_receiver_if.sv
// Bus bundle for batch_receiver: input stream, batch summary, replay stream,
// error pulse and running counters.
// Modports: slave = receiver side, master = environment side.
interface batch_receiver_if
  import svm_batch_pkg::*;
#(
  parameter int unsigned ID_WIDTH  = DEFAULT_ID_WIDTH,
  parameter int unsigned DEP_WIDTH = DEFAULT_DEP_WIDTH
);
  logic                 s_axis_tvalid;
  logic                 s_axis_tready;
  logic [ID_WIDTH-1:0]  s_axis_tdata_owner_programID;
  logic [DEP_WIDTH-1:0] s_axis_tdata_read_dependencies;
  logic [DEP_WIDTH-1:0] s_axis_tdata_write_dependencies;
  logic                 s_axis_tlast;

  logic                 m_sum_valid;
  logic                 m_sum_ready;
  logic [3:0]           m_sum_count;
  logic [DEP_WIDTH-1:0] m_sum_read_deps;
  logic [DEP_WIDTH-1:0] m_sum_write_deps;
  logic [3:0]           m_sum_conflict_cnt;

  logic                 m_axis_tvalid;
  logic                 m_axis_tready;
  logic [ID_WIDTH-1:0]  m_axis_tdata_owner_programID;
  logic [DEP_WIDTH-1:0] m_axis_tdata_read_dependencies;
  logic [DEP_WIDTH-1:0] m_axis_tdata_write_dependencies;
  logic                 m_axis_tconflict;
  logic                 m_axis_tlast;

  logic                 err_no_last;
  logic [31:0]          batches_received;
  logic [31:0]          conflicts_detected;

  modport slave (
    input  s_axis_tvalid, s_axis_tdata_owner_programID,
           s_axis_tdata_read_dependencies, s_axis_tdata_write_dependencies,
           s_axis_tlast, m_sum_ready, m_axis_tready,
    output s_axis_tready, m_sum_valid, m_sum_count, m_sum_read_deps,
           m_sum_write_deps, m_sum_conflict_cnt, m_axis_tvalid,
           m_axis_tdata_owner_programID, m_axis_tdata_read_dependencies,
           m_axis_tdata_write_dependencies, m_axis_tconflict, m_axis_tlast,
           err_no_last, batches_received, conflicts_detected
  );

  modport master (
    output s_axis_tvalid, s_axis_tdata_owner_programID,
           s_axis_tdata_read_dependencies, s_axis_tdata_write_dependencies,
           s_axis_tlast, m_sum_ready, m_axis_tready,
    input  s_axis_tready, m_sum_valid, m_sum_count, m_sum_read_deps,
           m_sum_write_deps, m_sum_conflict_cnt, m_axis_tvalid,
           m_axis_tdata_owner_programID, m_axis_tdata_read_dependencies,
           m_axis_tdata_write_dependencies, m_axis_tconflict, m_axis_tlast,
           err_no_last, batches_received, conflicts_detected
  );
endinterface

// File: rtl/dep_conflict_check.sv
// Combinational read/write overlap test of one transaction against the
// cumulative sets of earlier transactions in the batch.
// Ports: read_deps, write_deps (new beat), cum_read, cum_write (batch so far),
//        conflict_c (write hits any earlier access, or read hits earlier write).
module dep_conflict_check #(
  parameter int unsigned DEP_WIDTH = 1024
) (
  input  logic [DEP_WIDTH-1:0] read_deps,
  input  logic [DEP_WIDTH-1:0] write_deps,
  input  logic [DEP_WIDTH-1:0] cum_read,
  input  logic [DEP_WIDTH-1:0] cum_write,
  output logic                 conflict_c
);
  assign conflict_c = (|(write_deps & (cum_read | cum_write))) |
                      (|(read_deps & cum_write));
endmodule

// File: rtl/batch_receiver.sv
// Collects transactions into batches (closed by tlast or by reaching
// MAX_BATCH_SIZE), publishes a batch summary, then replays the stored
// transactions tagged with their dependency-conflict flag.
// Ports: clk, rst (synchronous, active high), bus (batch_receiver_if.slave).
// Optional feature: define BATCH_RX_CONFLICT_EN to build overlap detection;
// otherwise conflict outputs stay 0.
module batch_receiver
  import svm_batch_pkg::*;
#(
  parameter int unsigned MAX_BATCH_SIZE = 8,
  parameter int unsigned ID_WIDTH       = DEFAULT_ID_WIDTH,
  parameter int unsigned DEP_WIDTH      = DEFAULT_DEP_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  batch_receiver_if.slave   bus
);
  localparam int unsigned IDX_W = $clog2(MAX_BATCH_SIZE);

  rx_state_t            state;
  txn_t                 entries [MAX_BATCH_SIZE];
  logic [3:0]           count;
  logic [3:0]           idx;
  logic [3:0]           conf_cnt;
  logic [DEP_WIDTH-1:0] cum_r;
  logic [DEP_WIDTH-1:0] cum_w;
  logic                 s_ready;
  logic                 sum_valid;
  logic                 m_valid;
  logic [ID_WIDTH-1:0]  m_id;
  logic [DEP_WIDTH-1:0] m_rd;
  logic [DEP_WIDTH-1:0] m_wr;
  logic                 m_conf;
  logic                 m_last;
  logic                 err;
  logic [31:0]          batches;
  logic [31:0]          conflicts;
  logic                 conflict_c;
  logic [3:0]           rd_sel_c;
  txn_t                 next_c;

`ifdef BATCH_RX_CONFLICT_EN
  dep_conflict_check #(.DEP_WIDTH(DEP_WIDTH)) u_conflict (
    .read_deps  (bus.s_axis_tdata_read_dependencies),
    .write_deps (bus.s_axis_tdata_write_dependencies),
    .cum_read   (cum_r),
    .cum_write  (cum_w),
    .conflict_c (conflict_c)
  );
`else
  assign conflict_c = 1'b0;
`endif

  // Entry to present next: entry 0 when leaving SUMM, else the one after idx.
  always_comb begin
    rd_sel_c = 4'd0;
    if (state == DRAIN) rd_sel_c = idx + 4'd1;
    next_c = entries[IDX_W'(rd_sel_c)];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RECV;
      count     <= 4'd0;
      idx       <= 4'd0;
      conf_cnt  <= 4'd0;
      cum_r     <= '0;
      cum_w     <= '0;
      s_ready   <= 1'b1;
      sum_valid <= 1'b0;
      m_valid   <= 1'b0;
      m_id      <= '0;
      m_rd      <= '0;
      m_wr      <= '0;
      m_conf    <= 1'b0;
      m_last    <= 1'b0;
      err       <= 1'b0;
      batches   <= 32'd0;
      conflicts <= 32'd0;
    end else begin
      err <= 1'b0;
      case (state)
        RECV: begin
          if (bus.s_axis_tvalid) begin
            entries[IDX_W'(count)] <= '{
              owner_id:   DEFAULT_ID_WIDTH'(bus.s_axis_tdata_owner_programID),
              read_deps:  DEFAULT_DEP_WIDTH'(bus.s_axis_tdata_read_dependencies),
              write_deps: DEFAULT_DEP_WIDTH'(bus.s_axis_tdata_write_dependencies),
              conflict:   conflict_c
            };
            cum_r <= cum_r | bus.s_axis_tdata_read_dependencies;
            cum_w <= cum_w | bus.s_axis_tdata_write_dependencies;
            count <= count + 4'd1;
            if (conflict_c) conf_cnt <= conf_cnt + 4'd1;
            // Close on tlast, or force-close on the MAX-th beat.
            if (bus.s_axis_tlast || (count == 4'(MAX_BATCH_SIZE - 1))) begin
              state     <= SUMM;
              s_ready   <= 1'b0;
              sum_valid <= 1'b1;
              err       <= ~bus.s_axis_tlast;
            end
          end
        end
        SUMM: begin
          if (bus.m_sum_ready) begin
            state     <= DRAIN;
            sum_valid <= 1'b0;
            idx       <= 4'd0;
            m_valid   <= 1'b1;
            m_id      <= ID_WIDTH'(next_c.owner_id);
            m_rd      <= DEP_WIDTH'(next_c.read_deps);
            m_wr      <= DEP_WIDTH'(next_c.write_deps);
            m_conf    <= next_c.conflict;
            m_last    <= (count == 4'd1);
            batches   <= batches + 32'd1;
            conflicts <= conflicts + 32'(conf_cnt);
          end
        end
        DRAIN: begin
          if (bus.m_axis_tready) begin
            if (m_last) begin
              // Batch fully replayed: clear and reopen the input.
              state    <= RECV;
              m_valid  <= 1'b0;
              m_conf   <= 1'b0;
              m_last   <= 1'b0;
              count    <= 4'd0;
              conf_cnt <= 4'd0;
              cum_r    <= '0;
              cum_w    <= '0;
              s_ready  <= 1'b1;
            end else begin
              idx    <= idx + 4'd1;
              m_id   <= ID_WIDTH'(next_c.owner_id);
              m_rd   <= DEP_WIDTH'(next_c.read_deps);
              m_wr   <= DEP_WIDTH'(next_c.write_deps);
              m_conf <= next_c.conflict;
              m_last <= ((idx + 4'd2) == count);
            end
          end
        end
        default: state <= RECV;
      endcase
    end
  end

  // Summary fields come straight from the batch accumulators, which only
  // change in RECV, so they are stable while the summary is offered.
  assign bus.s_axis_tready                   = s_ready;
  assign bus.m_sum_valid                     = sum_valid;
  assign bus.m_sum_count                     = count;
  assign bus.m_sum_read_deps                 = cum_r;
  assign bus.m_sum_write_deps                = cum_w;
  assign bus.m_sum_conflict_cnt              = conf_cnt;
  assign bus.m_axis_tvalid                   = m_valid;
  assign bus.m_axis_tdata_owner_programID    = m_id;
  assign bus.m_axis_tdata_read_dependencies  = m_rd;
  assign bus.m_axis_tdata_write_dependencies = m_wr;
  assign bus.m_axis_tconflict                = m_conf;
  assign bus.m_axis_tlast                    = m_last;
  assign bus.err_no_last                     = err;
  assign bus.batches_received                = batches;
  assign bus.conflicts_detected              = conflicts;

endmodule

// File: tb/tb_batch_receiver.sv
// Directed self-checking bench for batch_receiver (default parameters).
// Expected conflict results follow BATCH_RX_CONFLICT_EN for the build.
module tb_batch_receiver;
  localparam int DW = 1024;
  typedef logic [DW-1:0] dep_t;
`ifdef BATCH_RX_CONFLICT_EN
  localparam bit CONF_EN = 1'b1;
`else
  localparam bit CONF_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  batch_receiver_if bus ();

  batch_receiver dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] e_id [16];
  dep_t        e_rd [16];
  dep_t        e_wr [16];
  bit          e_cf [16];
  int          e_n;
  dep_t        e_rmask, e_wmask;
  int          e_cc;
  int          exp_batches = 0;
  int          exp_conf = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic dep_t dbit(input int n);
    dep_t v;
    v = '0;
    v[n] = 1'b1;
    return v;
  endfunction

  task automatic new_batch();
    e_n = 0; e_rmask = '0; e_wmask = '0; e_cc = 0;
  endtask

  task automatic record(input logic [63:0] id, input dep_t rd, input dep_t wr, input bit cf);
    e_id[e_n] = id; e_rd[e_n] = rd; e_wr[e_n] = wr;
    e_cf[e_n] = cf && CONF_EN;
    if (cf && CONF_EN) e_cc++;
    e_rmask |= rd; e_wmask |= wr;
    e_n++;
  endtask

  task automatic drive(input logic [63:0] id, input dep_t rd, input dep_t wr, input bit last);
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata_owner_programID = id;
    bus.s_axis_tdata_read_dependencies = rd;
    bus.s_axis_tdata_write_dependencies = wr;
    bus.s_axis_tlast = last;
  endtask

  // Record expectation, present the beat and hold it until accepted.
  task automatic push(input logic [63:0] id, input dep_t rd, input dep_t wr, input bit last, input bit cf);
    int b;
    record(id, rd, wr, cf);
    drive(id, rd, wr, last);
    b = 0;
    while (!bus.s_axis_tready && b < 200) begin tick(); b++; end
    if (b >= 200) check_eq("s_ready_timeout", 1'b0, 1'b1);
    tick();
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast = 1'b0;
  endtask

  task automatic expect_summary(input int hold);
    int b;
    b = 0;
    while (!bus.m_sum_valid && b < 200) begin tick(); b++; end
    if (b >= 200) check_eq("sum_timeout", 1'b0, 1'b1);
    check_eq("sum_count", bus.m_sum_count, e_n);
    check_eq("sum_rmask", bus.m_sum_read_deps, e_rmask);
    check_eq("sum_wmask", bus.m_sum_write_deps, e_wmask);
    check_eq("sum_ccnt", bus.m_sum_conflict_cnt, e_cc);
    check_eq("err_quiet", bus.err_no_last, 1'b0);
    check_eq("s_ready_summ", bus.s_axis_tready, 1'b0);
    for (int i = 0; i < hold; i++) begin
      tick();
      check_eq("sum_hold_valid", bus.m_sum_valid, 1'b1);
      check_eq("sum_hold_count", bus.m_sum_count, e_n);
      check_eq("sum_hold_rmask", bus.m_sum_read_deps, e_rmask);
      check_eq("m_valid_early", bus.m_axis_tvalid, 1'b0);
    end
    bus.m_sum_ready = 1'b1;
    tick();
    bus.m_sum_ready = 1'b0;
    exp_batches++;
    exp_conf += e_cc;
    check_eq("sum_dropped", bus.m_sum_valid, 1'b0);
    check_eq("first_m_valid", bus.m_axis_tvalid, 1'b1);
    check_eq("batches", bus.batches_received, exp_batches);
    check_eq("conflicts", bus.conflicts_detected, exp_conf);
  endtask

  task automatic drain(input bit stall);
    int b;
    for (int i = 0; i < e_n; i++) begin
      if (stall) begin
        bus.m_axis_tready = 1'b0;
        tick();
        check_eq("stall_valid", bus.m_axis_tvalid, 1'b1);
        check_eq("stall_id", bus.m_axis_tdata_owner_programID, e_id[i]);
        check_eq("stall_last", bus.m_axis_tlast, (i == e_n - 1));
      end
      bus.m_axis_tready = 1'b1;
      b = 0;
      while (!bus.m_axis_tvalid && b < 200) begin tick(); b++; end
      if (b >= 200) check_eq("m_valid_timeout", 1'b0, 1'b1);
      check_eq("rep_id", bus.m_axis_tdata_owner_programID, e_id[i]);
      check_eq("rep_rd", bus.m_axis_tdata_read_dependencies, e_rd[i]);
      check_eq("rep_wr", bus.m_axis_tdata_write_dependencies, e_wr[i]);
      check_eq("rep_conf", bus.m_axis_tconflict, e_cf[i]);
      check_eq("rep_last", bus.m_axis_tlast, (i == e_n - 1));
      tick();
    end
    bus.m_axis_tready = 1'b0;
    check_eq("drain_done_valid", bus.m_axis_tvalid, 1'b0);
    check_eq("s_ready_reopen", bus.s_axis_tready, 1'b1);
  endtask

  task automatic check_reset_state();
    check_eq("rst_s_ready", bus.s_axis_tready, 1'b1);
    check_eq("rst_sum_valid", bus.m_sum_valid, 1'b0);
    check_eq("rst_sum_count", bus.m_sum_count, 4'd0);
    check_eq("rst_sum_rmask", bus.m_sum_read_deps, '0);
    check_eq("rst_m_valid", bus.m_axis_tvalid, 1'b0);
    check_eq("rst_m_id", bus.m_axis_tdata_owner_programID, 64'd0);
    check_eq("rst_m_rd", bus.m_axis_tdata_read_dependencies, '0);
    check_eq("rst_m_last", bus.m_axis_tlast, 1'b0);
    check_eq("rst_m_conf", bus.m_axis_tconflict, 1'b0);
    check_eq("rst_err", bus.err_no_last, 1'b0);
    check_eq("rst_batches", bus.batches_received, 32'd0);
    check_eq("rst_conflicts", bus.conflicts_detected, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata_owner_programID = '0;
    bus.s_axis_tdata_read_dependencies = '0;
    bus.s_axis_tdata_write_dependencies = '0;
    bus.s_axis_tlast = 1'b0;
    bus.m_sum_ready = 1'b0;
    bus.m_axis_tready = 1'b0;
    repeat (3) tick();
    check_reset_state();
    rst = 1'b0;
    tick();
    check_reset_state();

    // Three disjoint beats closed by tlast.
    new_batch();
    push(64'hA, dbit(1), dbit(10), 1'b0, 1'b0);
    push(64'hB, dbit(2), dbit(11), 1'b0, 1'b0);
    push(64'hC, dbit(3), dbit(12), 1'b1, 1'b0);
    check_eq("s1_rmask_abs", bus.m_sum_read_deps, dep_t'(16'h000E));
    check_eq("s1_wmask_abs", bus.m_sum_write_deps, dep_t'(16'h1C00));
    expect_summary(0);
    drain(1'b0);

    // Read-after-write overlap on the middle beat only.
    new_batch();
    push(64'h1, '0, dbit(5), 1'b0, 1'b0);
    push(64'h2, dbit(5), '0, 1'b0, 1'b1);
    push(64'h3, '0, dbit(7), 1'b1, 1'b0);
    check_eq("s2_rmask_abs", bus.m_sum_read_deps, dep_t'(16'h0020));
    check_eq("s2_wmask_abs", bus.m_sum_write_deps, dep_t'(16'h00A0));
    expect_summary(0);
    drain(1'b0);

    // Eight beats without tlast force-close; the ninth waits for the next batch.
    new_batch();
    for (int i = 0; i < 8; i++)
      push(64'h10 + 64'(i), dbit(20 + i), dbit(40 + i), 1'b0, 1'b0);
    drive(64'h99, dbit(100), dbit(200), 1'b1);
    check_eq("s3_err_pulse", bus.err_no_last, 1'b1);
    check_eq("s3_s_ready", bus.s_axis_tready, 1'b0);
    check_eq("s3_sum_valid", bus.m_sum_valid, 1'b1);
    tick();
    check_eq("s3_err_once", bus.err_no_last, 1'b0);
    check_eq("s3_count_max", bus.m_sum_count, 4'd8);
    expect_summary(0);
    drain(1'b0);
    new_batch();
    record(64'h99, dbit(100), dbit(200), 1'b0);
    tick();
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast = 1'b0;
    check_eq("s3_ninth_taken", bus.m_sum_valid, 1'b1);
    expect_summary(0);
    drain(1'b0);

    // Summary backpressure then alternating replay backpressure.
    new_batch();
    push(64'h21, dbit(30), dbit(31), 1'b0, 1'b0);
    push(64'h22, dbit(32), dbit(30), 1'b1, 1'b1);
    expect_summary(10);
    drain(1'b1);

    // Reset in the middle of a replay.
    new_batch();
    push(64'h31, dbit(60), '0, 1'b0, 1'b0);
    push(64'h32, dbit(61), '0, 1'b0, 1'b0);
    push(64'h33, dbit(62), '0, 1'b0, 1'b0);
    push(64'h34, dbit(63), '0, 1'b1, 1'b0);
    expect_summary(0);
    bus.m_axis_tready = 1'b1;
    tick();
    tick();
    check_eq("s5_idx2_id", bus.m_axis_tdata_owner_programID, 64'h33);
    bus.m_axis_tready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_state();
    exp_batches = 0;
    exp_conf = 0;
    new_batch();
    push(64'h41, dbit(9), dbit(9), 1'b1, 1'b0);
    expect_summary(0);
    drain(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/batch_receiver.md
# batch_receiver

Downstream end of the batch transaction stream. Receives transactions one at a time and groups them by `s_axis_tlast` into batches of at most MAX_BATCH_SIZE. For each transaction it flags read/write dependency overlap with earlier transactions in the same batch. When a batch closes, it publishes a batch summary and then replays the stored transactions, each tagged with its conflict flag, to the execution scheduler.

## Interface
Parameters:
- MAX_BATCH_SIZE, 8, maximum transactions per batch (2..15)
- ID_WIDTH, 64, owner program ID width
- DEP_WIDTH, 1024, read/write dependency bitmap width

Ports:
- clk  in  1  sole clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- s_axis_tvalid  in  1  input beat valid
- s_axis_tready  out  1  input beat accepted when high with tvalid
- s_axis_tdata_owner_programID  in  ID_WIDTH  transaction owner
- s_axis_tdata_read_dependencies  in  DEP_WIDTH  read set bitmap
- s_axis_tdata_write_dependencies  in  DEP_WIDTH  write set bitmap
- s_axis_tlast  in  1  beat is last of batch
- m_sum_valid  out  1  batch summary valid
- m_sum_ready  in  1  summary consumed
- m_sum_count  out  4  transactions in batch (1..MAX_BATCH_SIZE)
- m_sum_read_deps  out  DEP_WIDTH  OR of all read sets in batch
- m_sum_write_deps  out  DEP_WIDTH  OR of all write sets in batch
- m_sum_conflict_cnt  out  4  number of conflicted transactions in batch
- m_axis_tvalid, m_axis_tready, m_axis_tdata_owner_programID, m_axis_tdata_read_dependencies, m_axis_tdata_write_dependencies  out/in/out/out/out  1/1/ID/DEP/DEP  replay stream
- m_axis_tconflict  out  1  this transaction conflicts with an earlier one
- m_axis_tlast  out  1  final transaction of batch
- err_no_last  out  1  one-cycle pulse: batch force-closed at MAX without tlast
- batches_received  out  32  completed batches, wraps
- conflicts_detected  out  32  total conflicted transactions, wraps

## Operation
- FSM states: RECV, SUMM, DRAIN. Reset → RECV.
- RECV:
  - `s_axis_tready` = 1.
  - On handshake: store the beat at index `count`; compute its conflict flag (see below); OR the beat's read/write sets into the cumulative masks; increment `count`.
  - Go to SUMM when the beat has tlast, or when `count` reaches MAX_BATCH_SIZE (the MAX-th beat).
  - If the MAX-th beat lacks tlast, pulse `err_no_last`.
- Conflict flag: computed against the cumulative masks *before* the beat is ORed in. Flag = |(W & (cumR | cumW)) | |(R & cumW). The first beat never conflicts. Each conflicted beat increments the batch conflict count.
- SUMM:
  - `m_sum_valid` = 1; summary outputs hold stable until `m_sum_ready`.
  - On handshake: go to DRAIN with idx = 0; increment `batches_received`; add the batch conflict count to `conflicts_detected`.
- DRAIN:
  - `m_axis_tvalid` = 1 and presents entry[idx] with its conflict flag; `m_axis_tlast` = 1 when idx == count-1.
  - On handshake: idx++. After the tlast handshake: clear count, masks and conflict count, then return to RECV.
- `s_axis_tready` = 0 in SUMM and DRAIN. A new batch is never accepted while one is held.

## Timing
- Reset values:
  - All valids, `err_no_last`, `m_axis_tconflict` and `m_axis_tlast` = 0.
  - `s_axis_tready` = 1.
  - Counters, `m_sum_*` and `m_axis_tdata_*` = 0.
- Last input beat accepted at edge N → `m_sum_valid` high in cycle N+1.
- Summary handshake at edge S → first `m_axis_tvalid` in cycle S+1.
- Output handshake rules: AXI-Stream. Data stays stable while valid && !ready; valid is never dropped before handshake.
- Last drain handshake at edge D → `s_axis_tready` high in cycle D+1.
- Batch of k with no backpressure occupies k + 1 + k cycles.
- `err_no_last` is high in cycle N+1 only.
- Counter arithmetic is modulo 2^32, with no saturation.
- `rst` in any state (including mid-drain) aborts the batch and discards stored entries; no partial summary is emitted.

## Configuration
- BATCH_RX_CONFLICT_EN defined: conflict detection as above.
- Undefined: no overlap logic is built; `m_axis_tconflict`, `m_sum_conflict_cnt` and `conflicts_detected` are constant 0. Cumulative masks and all other behaviour are unchanged.

## Structure
- Package `svm_batch_pkg` holds:
  - ID_WIDTH and DEP_WIDTH defaults;
  - the FSM state encoding (RECV/SUMM/DRAIN);
  - the transaction record typedef (ID, read set, write set, conflict bit).
- Sub-module `dep_conflict_check`: combinational; inputs R, W, cumR, cumW; output conflict bit. Instantiated only under BATCH_RX_CONFLICT_EN.

## Test plan
- 3 beats (IDs 0xA, 0xB, 0xC) with disjoint deps (read bits 1, 2, 3; write bits 10, 11, 12), tlast on the 3rd → summary count=3, read mask bits {1,2,3}, write mask bits {10,11,12}, conflict_cnt=0. Replay emits A, B, C in order; tlast on C only; `batches_received`=1.
- Beat0 writes bit 5, beat1 reads bit 5, beat2 writes bit 7 (tlast) → conflict flags 0, 1, 0; conflict_cnt=1; `conflicts_detected`=1.
- 8 beats without tlast, 9th beat held valid → batch closes at 8, `err_no_last` pulses once, 9th beat stalls until the replay tlast handshake, then is accepted as entry 0 of the next batch.
- `m_sum_ready` low for 10 cycles, then `m_axis_tready` alternating 1/0 → summary and replay data stay stable while stalled; no duplicates or drops.
- `rst` asserted during DRAIN of a 4-beat batch at idx=2 → next cycle all outputs at reset values; a following 1-beat batch reports count=1.
- Build without BATCH_RX_CONFLICT_EN, rerun scenario 2 → all conflict flags 0, conflict_cnt=0, masks identical to scenario 2.
